regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL use one clock, clk, and an asynchronous active-high reset, rst.
REQ-002 Port list (name  direction  width  meaning):
 - clk  in  1  clock, rising edge
 - rst  in  1  async active-high reset
 - alu_valid  in  1  ALU writeback request
 - alu_rd  in  5  ALU destination register
 - alu_data  in  32  ALU result
 - alu_ready  out  1  ALU request accepted this cycle
 - ld_valid  in  1  load-unit writeback request
 - ld_rd  in  5  load destination register
 - ld_data  in  32  load result
 - ld_ready  out  1  load request accepted this cycle
 - claim_valid  in  1  issue stage reserves a destination
 - claim_rd  in  5  register being reserved
 - busy  out  32  per-register pending-write bitmap
 - rf_a3  out  5  register-file write address
 - rf_wd  out  32  register-file write data
 - rf_wen  out  1  register-file write enable

Function
REQ-003 Shares the single register-file write port between the ALU and load requesters.
REQ-004 Handshake: a transfer completes in a cycle where valid and ready are both 1; ready is combinational from valid and the arbitration state; valid, rd and data are held stable by the requester until accepted.
REQ-005 At most one ready is asserted per cycle; with exactly one valid, that requester gets ready the same cycle.
REQ-006 Both valid: round-robin; priority pointer prio (0=ALU, 1=load) selects the winner; after any completed transfer prio points to the non-winner.
REQ-007 Output stage registered: a transfer accepted in cycle N drives rf_wen=1, rf_a3=rd, rf_wd=data in cycle N+1; the register-file write commits at the end of cycle N+1.
REQ-008 Cycles with no transfer drive rf_wen=0 in the next cycle; rf_a3/rf_wd hold their previous values.
REQ-009 Transfer with rd=0: handshake completes normally, rf_wen stays 0 the next cycle, busy is unaffected.
REQ-010 Throughput: one accepted transfer per cycle sustained; back-to-back transfers are never stalled.
REQ-011 claim_valid with claim_rd!=0 sets busy[claim_rd] at the next edge; a claim of x0 is ignored; busy[0] is always 0.
REQ-012 busy[rf_a3] clears at the edge that ends a cycle with rf_wen=1.
REQ-013 Same edge sets and clears the same register: set wins (newer reservation).
REQ-014 A transfer to a register whose busy bit is 0 is legal; it writes and leaves busy at 0.

Reset
REQ-015 While rst=1: rf_wen=0, rf_a3=0, rf_wd=0, busy=0, prio=0 (ALU first); alu_ready and ld_ready are 0.
REQ-016 Assertion mid-operation drops any registered write not yet presented (rf_wen forced to 0 immediately); requesters hold and re-present after reset.
REQ-017 First arbitration after rst deasserts favours ALU.

Configuration
REQ-018 Macro WB_BYPASS_EN: when defined, adds outputs fwd_valid (1), fwd_rd (5) and fwd_data (32), driven combinationally in cycle N with the winning transfer's rd and data; fwd_valid=0 for rd=0 or no transfer.
REQ-019 WB_BYPASS_EN undefined: fwd_* ports absent; all other behaviour identical.

Verification
REQ-020 Single request: ALU valid, rd=5, data=0xDEADBEEF -> alu_ready same cycle; next cycle rf_wen=1, rf_a3=5, rf_wd=0xDEADBEEF.
REQ-021 Conflict: both valid held for 4 cycles from reset (ALU rd=1, load rd=2, each drops valid after accept, re-raises next cycle) -> grants alternate ALU, load, ALU, load; never both ready.
REQ-022 Scoreboard: claim rd=7 -> busy[7]=1 next cycle; load writes rd=7 -> busy[7]=0 at end of the rf_wen cycle; claim rd=7 in the rf_wen=1 cycle for rd=7 -> busy[7] stays 1.
REQ-023 x0: ALU valid, rd=0 -> ready asserted, rf_wen=0 next cycle; claim rd=0 -> busy stays 0.
REQ-024 Reset mid-stream: rst asserted the cycle after an accept -> rf_wen=0 immediately, busy=0, prio=0; after release, ALU wins the first conflict.
REQ-025 With WB_BYPASS_EN: load accepted rd=9, data=0x12345678 -> fwd_valid=1, fwd_rd=9, fwd_data=0x12345678 in the accept cycle.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port (ALU vs load), with a registered write stage
// and a busy bitmap for pending writes. Optional macro WB_BYPASS_EN adds a combinational forwarding port.
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        claim_valid,
  input  logic [4:0]  claim_rd,
  output logic [31:0] busy,
`ifdef WB_BYPASS_EN
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
`endif
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd,
  output logic        rf_wen
);

  logic        prio_q, prio_d;
  logic        rf_wen_q, rf_wen_d;
  logic [4:0]  rf_a3_q, rf_a3_d;
  logic [31:0] rf_wd_q, rf_wd_d;
  logic [31:0] busy_q, busy_d;

  logic        xfer;
  logic        win_wr;
  logic [4:0]  win_rd;
  logic [31:0] win_data;

  // prio_q: 0 favours the ALU, 1 favours the load unit when both request.
  always_comb begin
    alu_ready = 1'b0;
    ld_ready  = 1'b0;
    if (!rst) begin
      if (alu_valid && (!ld_valid || !prio_q)) alu_ready = 1'b1;
      else if (ld_valid)                        ld_ready  = 1'b1;
    end
    xfer     = alu_ready | ld_ready;
    win_rd   = ld_ready ? ld_rd   : alu_rd;
    win_data = ld_ready ? ld_data : alu_data;
    win_wr   = xfer && (win_rd != 5'd0);
  end

  always_comb begin
    prio_d = prio_q;
    if (alu_ready)     prio_d = 1'b1;
    else if (ld_ready) prio_d = 1'b0;

    rf_wen_d = win_wr;
    rf_a3_d  = win_wr ? win_rd   : rf_a3_q;
    rf_wd_d  = win_wr ? win_data : rf_wd_q;

    // A new claim overrides the clear of a write retiring on the same edge.
    busy_d = busy_q;
    if (rf_wen_q)    busy_d[rf_a3_q]  = 1'b0;
    if (claim_valid) busy_d[claim_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q   <= 1'b0;
      rf_wen_q <= 1'b0;
      rf_a3_q  <= 5'd0;
      rf_wd_q  <= 32'd0;
      busy_q   <= 32'd0;
    end else begin
      prio_q   <= prio_d;
      rf_wen_q <= rf_wen_d;
      rf_a3_q  <= rf_a3_d;
      rf_wd_q  <= rf_wd_d;
      busy_q   <= busy_d;
    end
  end

  assign rf_wen = rf_wen_q;
  assign rf_a3  = rf_a3_q;
  assign rf_wd  = rf_wd_q;
  assign busy   = busy_q;

`ifdef WB_BYPASS_EN
  assign fwd_valid = win_wr;
  assign fwd_rd    = win_rd;
  assign fwd_data  = win_data;
`endif

endmodule
